// File: rtl/rx_iq_intf_pkg.sv
// Shared encodings, rate-control defaults and I/Q packing helper for the
// multi-channel RX IQ interface.
package rx_iq_intf_pkg;

  localparam logic [1:0] SRC_BW20  = 2'd0;
  localparam logic [1:0] SRC_BW02  = 2'd1;
  localparam logic [1:0] SRC_SAXIS = 2'd2;  // 2'd3 aliases to s_axis as well

  localparam int DEF_PERIOD_SLOW = 10;
  localparam int DEF_PERIOD_FAST = 9;
  localparam int DEF_LOW_WM      = 12;
  localparam int DEF_HIGH_WM     = 20;

  // Bit offset of pair k inside a word: I at even slots, Q at odd slots.
  function automatic int iq_off(input int k, input int w, input bit is_q);
    return (2 * k + (is_q ? 1 : 0)) * w;
  endfunction

endpackage

// File: rtl/rx_iq_fifo_sync.sv
// First-word-fall-through synchronous FIFO with synchronous flush and fill count.
module rx_iq_fifo_sync #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wren,
  input  logic [DW-1:0] wdata,
  input  logic          rden,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  // count tops out at exactly 2**AW, so its MSB alone marks full.
  assign full  = count[AW];
  assign empty = (count == '0);
  assign wr    = wren & ~full & ~flush;
  assign rd    = rden & ~empty & ~flush;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr && !rst) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_iq_intf_mc.sv
// Multi-channel RX IQ interface: source select, FIFO buffering, fill-adaptive
// baseband drain rate, output channel routing and overflow/underflow stats.
module rx_iq_intf_mc
  import rx_iq_intf_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2,
  parameter int WORD_WIDTH    = 2 * IQ_DATA_WIDTH * NUM_CH,
  parameter int FIFO_AW       = 5,
  parameter int PERIOD_SLOW   = DEF_PERIOD_SLOW,
  parameter int PERIOD_FAST   = DEF_PERIOD_FAST,
  parameter int LOW_WM        = DEF_LOW_WM,
  parameter int HIGH_WM       = DEF_HIGH_WM,
  parameter int STAT_W        = 16,
  localparam int SW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_WIDTH-1:0]    bw20_iq,
  input  logic                     bw20_iq_valid,
  input  logic [WORD_WIDTH-1:0]    bw02_iq,
  input  logic                     bw02_iq_valid,
  input  logic [WORD_WIDTH-1:0]    data_from_s_axis,
  input  logic                     emptyn_from_s_axis,
  output logic                     ask_data_from_s_axis,
  output logic                     ask_data_from_adc,
  input  logic [1:0]               src_sel,
  input  logic                     ask_data_from_s_axis_en,
  input  logic                     fifo_in_en,
  input  logic                     fifo_out_en,
  input  logic                     bb_20M_en,
  input  logic                     fifo_flush,
  input  logic [SW-1:0]            out_ch_sel,
  input  logic                     rf_iq_valid_delay_sel,
  output logic [IQ_DATA_WIDTH-1:0] rf_i,
  output logic [IQ_DATA_WIDTH-1:0] rf_q,
  output logic                     rf_iq_valid,
  output logic [WORD_WIDTH-1:0]    rf_iq,
  output logic                     wifi_rx_iq_fifo_emptyn,
  output logic [FIFO_AW:0]         fifo_count,
  input  logic                     clear_stats,
  output logic [STAT_W-1:0]        overflow_cnt,
  output logic [STAT_W-1:0]        underflow_cnt
);

  localparam int PMAX = (PERIOD_SLOW > PERIOD_FAST) ? PERIOD_SLOW : PERIOD_FAST;
  localparam int CW   = $clog2(PMAX) + 1;
  localparam logic [CW-1:0]    P_SLOW = CW'(PERIOD_SLOW);
  localparam logic [CW-1:0]    P_FAST = CW'(PERIOD_FAST);
  localparam logic [FIFO_AW:0] LOW_C  = (FIFO_AW + 1)'(LOW_WM);
  localparam logic [FIFO_AW:0] HIGH_C = (FIFO_AW + 1)'(HIGH_WM);

  logic [CW-1:0]         rate_cnt, period;
  logic                  bb_en, full, empty, cand, wren, rden, rd_ok;
  logic                  ovf_inc, unf_inc, vld_q;
  logic [WORD_WIDTH-1:0] wdata, head, rf_iq_q;
  logic [SW-1:0]         ch_sel_q, ch_sel;
  logic [NUM_CH-1:0][IQ_DATA_WIDTH-1:0] ch_i, ch_q;

  // Rate strobe; the period only changes on the wrap so spacing is never torn.
  assign bb_en = (rate_cnt == '0) | bb_20M_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cnt <= '0;
      period   <= P_SLOW;
    end else if (rate_cnt == period - 1'b1) begin
      rate_cnt <= '0;
      if (fifo_count < LOW_C)       period <= P_SLOW;
      else if (fifo_count > HIGH_C) period <= P_FAST;
    end else begin
      rate_cnt <= rate_cnt + 1'b1;
    end
  end

  assign ask_data_from_s_axis = src_sel[1] & ask_data_from_s_axis_en & bb_en
                              & ~full & emptyn_from_s_axis;

  always_comb begin
    cand  = bw20_iq_valid;
    wdata = bw20_iq;
    case (src_sel)
      SRC_BW20: ;
      SRC_BW02: begin
        cand  = bw02_iq_valid;
        wdata = bw02_iq;
      end
      default: begin
        cand  = ask_data_from_s_axis;
        wdata = data_from_s_axis;
      end
    endcase
  end

  assign wren    = cand & fifo_in_en & ~full;
  assign rden    = bb_en & ~empty & fifo_out_en;
  assign rd_ok   = rden & ~fifo_flush;
  assign ovf_inc = cand & fifo_in_en & full;
  assign unf_inc = bb_en & fifo_out_en & empty & ~bb_20M_en;

  rx_iq_fifo_sync #(.DW(WORD_WIDTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .wren  (wren),
    .wdata (wdata),
    .rden  (rden),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign ask_data_from_adc      = ~full;
  assign wifi_rx_iq_fifo_emptyn = ~empty;

  // Registered output path; the channel select is captured with its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_iq_q  <= '0;
      vld_q    <= 1'b0;
      ch_sel_q <= '0;
    end else begin
      vld_q <= rd_ok;
      if (rd_ok) begin
        rf_iq_q  <= head;
        ch_sel_q <= out_ch_sel;
      end
    end
  end

  // Head is masked while empty so the bypass path never exposes stale RAM.
  assign rf_iq       = rf_iq_valid_delay_sel ? (empty ? '0 : head) : rf_iq_q;
  assign rf_iq_valid = rf_iq_valid_delay_sel ? rd_ok : vld_q;
  assign ch_sel      = rf_iq_valid_delay_sel ? out_ch_sel : ch_sel_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_i[k] = rf_iq[iq_off(k, IQ_DATA_WIDTH, 1'b0) +: IQ_DATA_WIDTH];
    assign ch_q[k] = rf_iq[iq_off(k, IQ_DATA_WIDTH, 1'b1) +: IQ_DATA_WIDTH];
  end

  always_comb begin
    rf_i = ch_i[0];
    rf_q = ch_q[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (ch_sel == SW'(k)) begin
        rf_i = ch_i[k];
        rf_q = ch_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else if (clear_stats) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else begin
      if (ovf_inc && !(&overflow_cnt))  overflow_cnt  <= overflow_cnt + 1'b1;
      if (unf_inc && !(&underflow_cnt)) underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_iq_intf_mc.sv
// Randomized bench for rx_iq_intf_mc against a queue-based behavioural model.
module tb_rx_iq_intf_mc;

  localparam int W = 16, NCH = 2, WW = 64, AW = 5, DEPTH = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic [WW-1:0] bw20_iq = '0, bw02_iq = '0, data_from_s_axis = '0;
  logic          bw20_iq_valid = 0, bw02_iq_valid = 0, emptyn_from_s_axis = 0;
  logic [1:0]    src_sel = '0;
  logic          ask_data_from_s_axis_en = 0, fifo_in_en = 0, fifo_out_en = 0;
  logic          bb_20M_en = 0, fifo_flush = 0, clear_stats = 0;
  logic          out_ch_sel = 0, rf_iq_valid_delay_sel = 0;
  logic          ask_data_from_s_axis, ask_data_from_adc, rf_iq_valid;
  logic          wifi_rx_iq_fifo_emptyn;
  logic [W-1:0]  rf_i, rf_q;
  logic [WW-1:0] rf_iq;
  logic [AW:0]   fifo_count;
  logic [15:0]   overflow_cnt, underflow_cnt;

  always #5 clk = ~clk;

  rx_iq_intf_mc #(.IQ_DATA_WIDTH(W), .NUM_CH(NCH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .bw20_iq(bw20_iq), .bw20_iq_valid(bw20_iq_valid),
    .bw02_iq(bw02_iq), .bw02_iq_valid(bw02_iq_valid),
    .data_from_s_axis(data_from_s_axis), .emptyn_from_s_axis(emptyn_from_s_axis),
    .ask_data_from_s_axis(ask_data_from_s_axis), .ask_data_from_adc(ask_data_from_adc),
    .src_sel(src_sel), .ask_data_from_s_axis_en(ask_data_from_s_axis_en),
    .fifo_in_en(fifo_in_en), .fifo_out_en(fifo_out_en), .bb_20M_en(bb_20M_en),
    .fifo_flush(fifo_flush), .out_ch_sel(out_ch_sel),
    .rf_iq_valid_delay_sel(rf_iq_valid_delay_sel),
    .rf_i(rf_i), .rf_q(rf_q), .rf_iq_valid(rf_iq_valid), .rf_iq(rf_iq),
    .wifi_rx_iq_fifo_emptyn(wifi_rx_iq_fifo_emptyn), .fifo_count(fifo_count),
    .clear_stats(clear_stats), .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
  );

  // behavioural model state
  logic [WW-1:0] q[$];
  int            rcnt, period, m_ovf, m_unf, cyc;
  logic [WW-1:0] reg_word;
  logic          reg_vld, reg_sel;
  bit            e_bb, e_ask, e_cand, e_wr, e_rd, e_full, e_empty;
  int            nvec, nerr;
  int            vt[$];
  bit            meas;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pair_i(input logic [63:0] w, input int k);
    return 16'(w >> (32 * k));
  endfunction
  function automatic logic [15:0] pair_q(input logic [63:0] w, input int k);
    return 16'(w >> (32 * k + 16));
  endfunction
  function automatic logic [63:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    rcnt = 0; period = 10; m_ovf = 0; m_unf = 0;
    reg_word = '0; reg_vld = 0; reg_sel = 0;
  endtask

  task automatic model_eval();
    e_full  = (q.size() == DEPTH);
    e_empty = (q.size() == 0);
    e_bb    = (rcnt == 0) || bb_20M_en;
    e_ask   = (src_sel >= 2) && ask_data_from_s_axis_en && e_bb && !e_full && emptyn_from_s_axis;
    case (src_sel)
      2'd0:    e_cand = bw20_iq_valid;
      2'd1:    e_cand = bw02_iq_valid;
      default: e_cand = e_ask;
    endcase
    e_wr = e_cand && fifo_in_en && !e_full && !fifo_flush;
    e_rd = e_bb && !e_empty && fifo_out_en && !fifo_flush;
  endtask

  task automatic check_all();
    logic [63:0] ew;
    int          s;
    chk("ask_s",  64'(ask_data_from_s_axis), 64'(e_ask));
    chk("ask_adc", 64'(ask_data_from_adc), 64'(!e_full));
    chk("emptyn", 64'(wifi_rx_iq_fifo_emptyn), 64'(!e_empty));
    chk("count",  64'(fifo_count), 64'(q.size()));
    if (rf_iq_valid_delay_sel) begin
      ew = '0;
      if (!e_empty) ew = q[0];
      s = int'(out_ch_sel);
      chk("valid_c", 64'(rf_iq_valid), 64'(e_rd));
    end else begin
      ew = reg_word;
      s = int'(reg_sel);
      chk("valid_r", 64'(rf_iq_valid), 64'(reg_vld));
    end
    chk("rf_iq", rf_iq, ew);
    chk("rf_i", 64'(rf_i), 64'(pair_i(ew, s)));
    chk("rf_q", 64'(rf_q), 64'(pair_q(ew, s)));
    chk("ovf", 64'(overflow_cnt), 64'(m_ovf));
    chk("unf", 64'(underflow_cnt), 64'(m_unf));
    if (meas && rf_iq_valid) vt.push_back(cyc);
  endtask

  task automatic model_update();
    int          sz;
    logic [63:0] wd;
    sz = q.size();
    case (src_sel)
      2'd0:    wd = bw20_iq;
      2'd1:    wd = bw02_iq;
      default: wd = data_from_s_axis;
    endcase
    if (e_rd) begin
      reg_word = q.pop_front();
      reg_sel  = out_ch_sel;
    end
    reg_vld = e_rd;
    if (e_wr) q.push_back(wd);
    if (fifo_flush) q.delete();
    if (rcnt == period - 1) begin
      rcnt = 0;
      if (sz < 12) period = 10;
      else if (sz > 20) period = 9;
    end else begin
      rcnt++;
    end
    if (clear_stats) m_ovf = 0;
    else if (e_cand && fifo_in_en && e_full && m_ovf < 65535) m_ovf++;
    if (clear_stats) m_unf = 0;
    else if (e_bb && fifo_out_en && e_empty && !bb_20M_en && m_unf < 65535) m_unf++;
    cyc++;
  endtask

  task automatic step();
    #1;
    model_eval();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; meas = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_adc", 64'(ask_data_from_adc), 64'd1);
    chk("rst_cnt", 64'(fifo_count), 64'd0);
    chk("rst_vld", 64'(rf_iq_valid), 64'd0);

    // fill from bw20 until full, then overflow
    src_sel = 2'd0; fifo_in_en = 1; bw20_iq_valid = 1;
    for (int i = 0; i < 40; i++) begin bw20_iq = rnd_word(); step(); end
    chk("full_adc", 64'(ask_data_from_adc), 64'd0);
    clear_stats = 1; step(); clear_stats = 0;
    for (int i = 0; i < 5; i++) begin bw20_iq = rnd_word(); step(); end
    chk("ovf5", 64'(overflow_cnt), 64'd5);
    for (int i = 0; i < 65539; i++) step();
    chk("ovf_sat", 64'(overflow_cnt), 64'hFFFF);
    bw20_iq_valid = 0; clear_stats = 1; step(); clear_stats = 0;

    // drain from full via bypass output, measuring strobe spacing
    fifo_in_en = 0; fifo_out_en = 1; rf_iq_valid_delay_sel = 1; meas = 1;
    for (int i = 0; i < 340; i++) step();
    meas = 0;
    chk("drain_n", 64'(vt.size()), 64'd32);
    if (vt.size() >= 2) begin
      chk("gap_first", 64'(vt[1] - vt[0]), 64'd9);
      chk("gap_last", 64'(vt[vt.size()-1] - vt[vt.size()-2]), 64'd10);
    end

    // bb_20M_en streaming, both output modes
    clear_stats = 1; step(); clear_stats = 0;
    bb_20M_en = 1; fifo_in_en = 1; bw20_iq_valid = 1;
    for (int i = 0; i < 40; i++) begin
      rf_iq_valid_delay_sel = (i >= 20);
      bw20_iq = rnd_word();
      step();
    end
    bw20_iq_valid = 0;
    repeat (5) step();
    chk("unf_bb20", 64'(underflow_cnt), 64'd0);

    // s_axis loopback fill, then underflow with no source data
    bb_20M_en = 0; fifo_out_en = 0; src_sel = 2'd2;
    ask_data_from_s_axis_en = 1; emptyn_from_s_axis = 1;
    for (int i = 0; i < 400; i++) begin data_from_s_axis = rnd_word(); step(); end
    chk("saxis_full", 64'(fifo_count), 64'd32);
    fifo_flush = 1; step(); fifo_flush = 0;
    emptyn_from_s_axis = 0; fifo_out_en = 1;
    clear_stats = 1; step(); clear_stats = 0;
    for (int i = 0; i < 60; i++) step();

    // channel routing
    fifo_out_en = 0; src_sel = 2'd0; ask_data_from_s_axis_en = 0;
    bw20_iq = 64'h0004_0003_0002_0001; bw20_iq_valid = 1; step();
    bw20_iq_valid = 0; rf_iq_valid_delay_sel = 1; out_ch_sel = 1; step();
    chk("route1_i", 64'(rf_i), 64'h3);
    chk("route1_q", 64'(rf_q), 64'h4);
    out_ch_sel = 0; #1;
    chk("route0_i", 64'(rf_i), 64'h1);
    chk("route0_q", 64'(rf_q), 64'h2);
    rf_iq_valid_delay_sel = 0; out_ch_sel = 1; fifo_out_en = 1;
    for (int i = 0; i < 12; i++) step();

    // flush at fill 10 together with write and read
    fifo_out_en = 0; bw20_iq_valid = 1;
    for (int i = 0; i < 10; i++) begin bw20_iq = rnd_word(); step(); end
    chk("fill10", 64'(fifo_count), 64'd10);
    fifo_flush = 1; bb_20M_en = 1; fifo_out_en = 1; step();
    fifo_flush = 0; bb_20M_en = 0; fifo_out_en = 0; bw20_iq_valid = 0; #1;
    chk("flush_cnt", 64'(fifo_count), 64'd0);
    chk("flush_emptyn", 64'(wifi_rx_iq_fifo_emptyn), 64'd0);
    chk("flush_vld", 64'(rf_iq_valid), 64'd0);

    // randomized traffic with an asynchronous reset mid-burst
    for (int i = 0; i < 3000; i++) begin
      src_sel = 2'($urandom_range(0, 3));
      bw20_iq_valid = 1'($urandom_range(0, 1));
      bw02_iq_valid = 1'($urandom_range(0, 1));
      bw20_iq = rnd_word(); bw02_iq = rnd_word(); data_from_s_axis = rnd_word();
      emptyn_from_s_axis = ($urandom_range(0, 3) != 0);
      ask_data_from_s_axis_en = ($urandom_range(0, 3) != 0);
      fifo_in_en  = ($urandom_range(0, 3) != 0);
      fifo_out_en = ($urandom_range(0, 3) != 0);
      bb_20M_en   = ($urandom_range(0, 7) == 0);
      fifo_flush  = ($urandom_range(0, 63) == 0);
      clear_stats = ($urandom_range(0, 127) == 0);
      out_ch_sel  = 1'($urandom_range(0, 1));
      rf_iq_valid_delay_sel = 1'($urandom_range(0, 1));
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", 64'(fifo_count), 64'd0);
        chk("arst_adc", 64'(ask_data_from_adc), 64'd1);
        chk("arst_ovf", 64'(overflow_cnt), 64'd0);
        chk("arst_vld", 64'(rf_iq_valid), 64'd0);
        chk("arst_iq", rf_iq, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
